inst_fetch_unit: RTL
====================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning instruction and PC width.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning instruction memory size in words (power of 2).
REQ-003 The block SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port inst_wdata  in  XLEN  instruction word to load.
REQ-006 The block SHALL have port inst_wen  in  1  load strobe, one word per cycle.
REQ-007 The block SHALL have port load_clr  in  1  clears the load pointer for a fresh program.
REQ-008 The block SHALL have port execute  in  1  start-of-run request.
REQ-009 The block SHALL have port stall  in  1  downstream decoder not ready.
REQ-010 The block SHALL have port br_taken  in  1  redirect request.
REQ-011 The block SHALL have port br_target  in  XLEN  redirect byte address.
REQ-012 The block SHALL have port inst_out  out  XLEN  fetched instruction.
REQ-013 The block SHALL have port pc_out  out  XLEN  byte address of inst_out.
REQ-014 The block SHALL have port inst_valid  out  1  inst_out/pc_out valid.
REQ-015 The block SHALL have port load_count  out  log2(DEPTH)+1  words loaded.
REQ-016 The block SHALL have ports load_full  out  1  (load_count==DEPTH) and busy  out  1  (state is FETCH).

Function
REQ-017 The block SHALL implement states IDLE and FETCH.
REQ-018 In IDLE, inst_wen=1 with load_count<DEPTH SHALL write mem[load_count] and increment load_count; writes at load_count==DEPTH SHALL be dropped.
REQ-019 In IDLE, load_clr=1 SHALL set load_count to 0 and take priority over a same-cycle inst_wen; memory contents SHALL NOT be cleared.
REQ-020 inst_wen and load_clr SHALL be ignored in FETCH.
REQ-021 In IDLE, execute=1 with nonzero post-write load_count SHALL enter FETCH with fetch_pc=0; execute with load_count==0 SHALL be ignored; a same-cycle write SHALL count.
REQ-022 Memory read SHALL be synchronous: the word at fetch_pc appears on inst_out with pc_out=fetch_pc and inst_valid=1 one cycle after issue.
REQ-023 With stall=0, each FETCH cycle SHALL issue fetch_pc and advance fetch_pc by 4.
REQ-024 With stall=1, fetch_pc, inst_out, pc_out and inst_valid SHALL hold.
REQ-025 br_taken=1 in FETCH SHALL override stall: fetch_pc<=br_target with bits[1:0] forced to 0, inst_valid=0 next cycle, target word valid the cycle after.
REQ-026 An issue with fetch_pc/4 >= load_count SHALL NOT raise inst_valid; the block SHALL return to IDLE once no valid output is pending (inst_valid=0, or stall=0).
REQ-027 execute SHALL be ignored in FETCH; br_taken SHALL be ignored in IDLE.

Reset
REQ-028 rst=1 SHALL set state IDLE, load_count=0, fetch_pc=0, inst_out=0, pc_out=0, inst_valid=0, busy=0, load_full=0, and SHALL abort a run in progress the same edge; memory contents SHALL be unspecified.

Verification
REQ-029 Load 3 words 0x11,0x22,0x33, execute pulse -> inst_valid 3 consecutive cycles with (pc_out,inst_out)=(0,0x11),(4,0x22),(8,0x33), then busy=0.
REQ-030 Run of 3 with stall=1 for 2 cycles while pc_out=4 -> inst_out=0x22 held 3 cycles, no word lost or duplicated.
REQ-031 Load 5 words, br_taken with br_target=0x0D while pc_out=0 -> one bubble, next valid pc_out=0xC, then 0x10, then IDLE.
REQ-032 Write DEPTH+2 words -> load_count=DEPTH, load_full=1; load_clr -> load_count=0; execute -> stays IDLE.
REQ-033 rst asserted mid-run -> next cycle inst_valid=0, busy=0, load_count=0.
REQ-034 br_taken with br_target=DEPTH*4 -> no further valid output, return to IDLE.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inst_fetch_unit_if                                           |
// | Description : Load/control/fetch-output bundle for the instruction fetcher.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface inst_fetch_unit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64
);
    localparam int c_AW = $clog2(DEPTH);

    logic [XLEN-1:0] inst_wdata;
    logic            inst_wen;
    logic            load_clr;
    logic            execute;
    logic            stall;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] pc_out;
    logic            inst_valid;
    logic [c_AW:0]   load_count;
    logic            load_full;
    logic            busy;

    modport master (
        output inst_wdata, inst_wen, load_clr, execute, stall, br_taken, br_target,
        input  inst_out, pc_out, inst_valid, load_count, load_full, busy
    );

    modport slave (
        input  inst_wdata, inst_wen, load_clr, execute, stall, br_taken, br_target,
        output inst_out, pc_out, inst_valid, load_count, load_full, busy
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inst_fetch_unit                                              |
// | Description : Loadable instruction store with sequential/branching fetch.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module inst_fetch_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    inst_fetch_unit_if.slave      bus
);
    localparam int              c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH_CNT = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE   = (c_AW+1)'(1);
    localparam logic [XLEN-1:0] c_PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] c_ALIGN     = ~XLEN'(3);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    logic [XLEN-1:0] r_mem [DEPTH];

    state_t          r_state,      w_state_nxt;
    logic [c_AW:0]   r_load_count, w_load_count_nxt;
    logic [XLEN-1:0] r_fetch_pc,   w_fetch_pc_nxt;
    logic [XLEN-1:0] r_inst_out,   w_inst_out_nxt;
    logic [XLEN-1:0] r_pc_out,     w_pc_out_nxt;
    logic            r_inst_valid, w_inst_valid_nxt;

    logic            w_mem_we;
    logic            w_full;
    logic            w_in_range;
    logic [XLEN-1:0] w_word_idx;
    logic [c_AW-1:0] w_rd_idx;
    logic [c_AW-1:0] w_wr_idx;

    assign w_full     = (r_load_count == c_DEPTH_CNT);
    assign w_word_idx = {2'b00, r_fetch_pc[XLEN-1:2]};
    // Full-width compare so targets far beyond the store are still out of range.
    assign w_in_range = (w_word_idx < XLEN'(r_load_count));
    assign w_rd_idx   = r_fetch_pc[c_AW+1:2];
    assign w_wr_idx   = r_load_count[c_AW-1:0];

    always_comb begin
        w_state_nxt      = r_state;
        w_load_count_nxt = r_load_count;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_inst_out_nxt   = r_inst_out;
        w_pc_out_nxt     = r_pc_out;
        w_inst_valid_nxt = r_inst_valid;
        w_mem_we         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_inst_valid_nxt = 1'b0;
                if (bus.load_clr) begin
                    w_load_count_nxt = '0;
                end else if (bus.inst_wen && !w_full) begin
                    w_mem_we         = 1'b1;
                    w_load_count_nxt = r_load_count + c_CNT_ONE;
                end
                // Post-write count decides, so a same-cycle write can start a run.
                if (bus.execute && (w_load_count_nxt != '0)) begin
                    w_state_nxt    = S_FETCH;
                    w_fetch_pc_nxt = '0;
                end
            end

            S_FETCH: begin
                if (bus.br_taken) begin
                    w_fetch_pc_nxt   = bus.br_target & c_ALIGN;
                    w_inst_valid_nxt = 1'b0;
                end else if (!w_in_range) begin
                    // Leave only once the last valid word has been accepted.
                    if (!r_inst_valid || !bus.stall) begin
                        w_inst_valid_nxt = 1'b0;
                        w_state_nxt      = S_IDLE;
                    end
                end else if (!bus.stall) begin
                    w_inst_out_nxt   = r_mem[w_rd_idx];
                    w_pc_out_nxt     = r_fetch_pc;
                    w_inst_valid_nxt = 1'b1;
                    w_fetch_pc_nxt   = r_fetch_pc + c_PC_STEP;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_load_count <= '0;
            r_fetch_pc   <= '0;
            r_inst_out   <= '0;
            r_pc_out     <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_load_count <= w_load_count_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_inst_out   <= w_inst_out_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_wr_idx] <= bus.inst_wdata;
        end
    end

    assign bus.inst_out   = r_inst_out;
    assign bus.pc_out     = r_pc_out;
    assign bus.inst_valid = r_inst_valid;
    assign bus.load_count = r_load_count;
    assign bus.load_full  = w_full;
    assign bus.busy       = (r_state == S_FETCH);

endmodule
`default_nettype wire
